// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - ALU control codes {A_invert, B_invert, op[1:0]}
//   - FSM state encoding used by alu_seq
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational invert/AND/OR/add/SLT datapath.
// Ports:
//   a_i, b_i    : WIDTH-bit operands
//   ctrl_i      : {A_invert, B_invert, op[1:0]}; op 00 AND, 01 OR, 10 add, 11 SLT
//   result_o    : WIDTH-bit result
//   cout_o      : carry out of the MSB (add op only)
//   overflow_o  : signed overflow (add op only)
// NOR falls out naturally as AND with both inputs inverted.
module alu_comb_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  always_comb begin
    a_eff   = ctrl_i[3] ? ~a_i : a_i;
    b_eff   = ctrl_i[2] ? ~b_i : b_i;
    // Inverting B also injects the carry-in, giving two's-complement subtract.
    sum     = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ctrl_i[2]};
    add_ovf = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);

    result_o   = '0;
    cout_o     = 1'b0;
    overflow_o = 1'b0;
    case (ctrl_i[1:0])
      2'b00: result_o = a_eff & b_eff;
      2'b01: result_o = a_eff | b_eff;
      2'b10: begin
        result_o   = sum[WIDTH-1:0];
        cout_o     = sum[WIDTH];
        overflow_o = add_ovf;
      end
      // Signed less-than: sign of the difference corrected by overflow.
      default: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU with valid/ready handshakes.
// Ports:
//   clk_i, rst_i          : clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o : operand handshake; ready only in IDLE
//   src1_i, src2_i, ctrl_i: operands and {A_inv, B_inv, op}
//   out_valid_o/out_ready_i: result handshake; result held until consumed
//   result_o, zero_o, cout_o, overflow_o: registered result and flags
// Single-cycle ops register at the accept edge; MUL iterates WIDTH
// shift-add steps. Unsupported codes complete with result and flags 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_ovf;
  logic             is_mul;
  logic             is_basic;
  logic [WIDTH-1:0] acc_step;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (src1_i),
    .b_i        (src2_i),
    .ctrl_i     (ctrl_i),
    .result_o   (core_res),
    .cout_o     (core_cout),
    .overflow_o (core_ovf)
  );

  always_comb begin
    is_mul = MUL_EN && (ctrl_i == ALU_MUL);
    case (ctrl_i)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_basic = 1'b1;
      default:                                             is_basic = 1'b0;
    endcase
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (is_mul) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            // Unsupported codes report zero_o=0 even though the result is 0.
            result_d = is_basic ? core_res  : '0;
            cout_d   = is_basic ? core_cout : 1'b0;
            ovf_d    = is_basic ? core_ovf  : 1'b0;
            zero_d   = is_basic && (core_res == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand-written multi-cycle sequences and random
// ops checked against an arithmetic reference model of the ALU.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  src1;
  logic [W-1:0]  src2;
  logic [3:0]    ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          cout;
  logic          ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .src1_i      (src1),
    .src2_i      (src2),
    .ctrl_i      (ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .zero_o      (zero),
    .cout_o      (cout),
    .overflow_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         co;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic meaning of each operation.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic co,
                                output logic ov, output int lat);
    longint      sa, sb, s;
    logic [63:0] p;
    logic        sup;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    sup = 1'b1;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        p  = {32'b0, a} + {32'b0, b};
        r  = p[W-1:0];
        co = p[W];
        s  = sa + sb;
        ov = (s != longint'($signed(r)));
      end
      4'b0110: begin
        r  = a - b;
        co = (a >= b);
        s  = sa - sb;
        ov = (s != longint'($signed(r)));
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: r = ~(a | b);
      4'b1000: begin
        p   = {32'b0, a} * {32'b0, b};
        r   = p[W-1:0];
        lat = W + 1;
      end
      default: sup = 1'b0;
    endcase
    z = sup && (r == '0);
  endfunction

  // Issue one op, wait for the result, hold it 'hold' cycles, then consume.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] r, output logic z,
                        output logic co, output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    ctrl     = c;
    src1     = a;
    src2     = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r  = result;
    z  = zero;
    co = cout;
    ov = ovf;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [W-1:0] r_act, r_exp;
  logic         z_act, c_act, v_act, z_exp, c_exp, v_exp;
  int           lat_act, lat_exp;
  logic         seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src1      = '0;
    src2      = '0;
    ctrl      = '0;

    vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{ALU_OR,  32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{ALU_NOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[9]  = '{4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{ALU_MUL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33};
    vecs[11] = '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", {zero, cout, ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, 0, r_act, z_act, c_act, v_act, lat_act);
      check($sformatf("vec%0d_result", i), r_act, vecs[i].r);
      check($sformatf("vec%0d_zcv", i), {z_act, c_act, v_act}, {vecs[i].z, vecs[i].co, vecs[i].ov});
      check($sformatf("vec%0d_latency", i), lat_act, vecs[i].lat);
    end

    // MUL: in_ready low throughout, a stray in_valid pulse is ignored
    in_valid = 1'b1; ctrl = ALU_MUL; src1 = 32'h0000FFFF; src2 = 32'h00010001;
    @(negedge clk);
    in_valid = 1'b0;
    lat_act  = 1;
    seen     = 1'b0;
    while (!out_valid && lat_act < 200) begin
      if (in_ready) seen = 1'b1;
      if (lat_act == 5) begin
        in_valid = 1'b1; ctrl = ALU_ADD; src1 = 32'd1; src2 = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat_act++;
    end
    in_valid = 1'b0;
    check("mul_in_ready_low", seen, 0);
    check("mul_latency", lat_act, 33);
    check("mul_result", result, 32'hFFFFFFFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    check("mul_no_ghost_op", out_valid, 0);

    // Backpressure on AND
    in_valid = 1'b1; ctrl = ALU_AND; src1 = 32'hF0F0F0F0; src2 = 32'hFF00FF00;
    @(negedge clk);
    in_valid = 1'b0;
    src1 = 32'h0; src2 = 32'h0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || result !== 32'hF000F000 || in_ready) seen = 1'b1;
      @(negedge clk);
    end
    check("bp_held_stable", seen, 0);
    check("bp_result", result, 32'hF000F000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready", in_ready, 1);

    // Reset at MUL step 10
    in_valid = 1'b1; ctrl = ALU_MUL; src1 = 32'd7; src2 = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {zero, cout, ovf}, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("midrst_no_pulse", seen, 0);
    run_op(ALU_ADD, 32'd2, 32'd3, 0, r_act, z_act, c_act, v_act, lat_act);
    check("post_rst_add", r_act, 5);
    run_op(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r_act, z_act, c_act, v_act, lat_act);
    check("post_rst_unsup_result", r_act, 0);
    check("post_rst_unsup_flags", {z_act, c_act, v_act}, 0);

    // Random ops against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0]   c;
      logic [W-1:0] a, b;
      case ($urandom_range(0, 7))
        0: c = ALU_AND;
        1: c = ALU_OR;
        2: c = ALU_ADD;
        3: c = ALU_SUB;
        4: c = ALU_SLT;
        5: c = ALU_NOR;
        6: c = ALU_MUL;
        default: c = 4'($urandom_range(0, 15));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {1'b0, {(W-1){1'b1}}};
      model(c, a, b, r_exp, z_exp, c_exp, v_exp, lat_exp);
      run_op(c, a, b, $urandom_range(0, 3), r_act, z_act, c_act, v_act, lat_act);
      check($sformatf("rnd%0d_c%0h_result", n, c), r_act, r_exp);
      check($sformatf("rnd%0d_c%0h_zcv", n, c), {z_act, c_act, v_act}, {z_exp, c_exp, v_exp});
      check($sformatf("rnd%0d_c%0h_latency", n, c), lat_act, lat_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
WIDTH-bit sequential ALU for the lab CPU datapath. Supports the classic invert/op ALU control set (AND, OR, ADD, SUB, SLT, NOR), plus an iterative unsigned multiply. Inputs arrive on a valid/ready handshake; the result and the zero/carry/overflow flags are registered and held until consumed. It replaces the purely combinational ALU in the multi-cycle CPU variant.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
MUL_EN, 1, 1 = MUL supported; 0 = MUL code treated as unsupported

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
in_valid_i  in  1  operand/ctrl valid
in_ready_o  out  1  block can accept; equals (state==IDLE)
src1_i  in  WIDTH  operand A
src2_i  in  WIDTH  operand B
ctrl_i  in  4  {A_invert, B_invert, op[1:0]}; see Behaviour
out_valid_o  out  1  result/flags valid
out_ready_i  in  1  consumer accepts result
result_o  out  WIDTH  registered result
zero_o  out  1  result_o == 0
cout_o  out  1  carry out of MSB (ADD/SUB only)
overflow_o  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (rst_i low, async): state=IDLE, out_valid_o=0, result_o=0, zero_o=0, cout_o=0, overflow_o=0, multiply counter/accumulator=0. in_ready_o=1 while in IDLE, including during reset.
- ctrl_i codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (B inverted, cin=1), 0111 SLT, 1100 NOR (~A & ~B), 1000 MUL. All other codes, and MUL when MUL_EN=0, are unsupported: result 0, all flags 0, latency 1.
- Accept = in_valid_i & in_ready_o. Operands and ctrl are captured at the accept edge. Inputs are ignored when not in IDLE.
- States: IDLE, MUL, DONE.
- IDLE, non-MUL accept: compute combinationally and register result/flags at the same edge. Go to DONE. out_valid_o is high in the next cycle (latency 1).
- IDLE, MUL accept: load multiplicand/multiplier, clear accumulator and counter. Go to MUL.
- MUL: one shift-add step per cycle, unsigned, keeping the low WIDTH bits. After WIDTH steps (counter WIDTH-1 → done), register the result and go to DONE. out_valid_o rises WIDTH+1 cycles after the accept edge. MUL sets cout_o=0 and overflow_o=0.
- DONE: out_valid_o=1. result_o and flags stay stable until out_valid_o & out_ready_i. On that handshake edge go to IDLE and clear out_valid_o. No accept occurs in the same cycle, so peak throughput is one op per 2 cycles.
- ADD/SUB: sum = s1 + s2 + cin at WIDTH+1 bits. cout_o = bit WIDTH. overflow_o = (s1[MSB]==s2[MSB]) & (sum[MSB]!=s1[MSB]).
- SLT: signed A<B, computed as sub[MSB] XOR sub_overflow. result = {0…,lt}. cout_o=0, overflow_o=0.
- AND/OR/NOR: cout_o=0, overflow_o=0.
- zero_o is computed from the registered result for every op.
- Reset asserted mid-MUL or in DONE aborts immediately. The pending result is lost and no out_valid_o pulse follows.
- out_ready_i held high in IDLE/MUL has no effect.

Decomposition:
- Package alu_pkg holds:
  - ctrl code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL)
  - state encoding (S_IDLE, S_MUL, S_DONE)
- One sub-module, alu_comb_core: combinational WIDTH-bit invert/AND/OR/add/SLT datapath producing result, cout and overflow. alu_seq owns the FSM, handshake, multiply iteration and output registers.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 (WIDTH=32) → result 0x80000000, overflow 1, cout 0, zero 0, out_valid_o exactly 1 cycle after accept.
- SUB 0x00000005−0x00000005 → result 0, zero 1, cout 1, overflow 0.
- SLT with operand pairs:
  - 0xFFFFFFFF vs 0x00000001 → 1
  - 0x00000001 vs 0xFFFFFFFF → 0
  - 0x80000000 vs 0x7FFFFFFF → 1 (overflow path)
  - In all cases cout=overflow=0.
- MUL 0x0000FFFF×0x00010001 → result 0xFFFFFFFF. out_valid_o exactly 33 cycles after accept; in_ready_o low throughout; a second in_valid_i pulse during MUL is ignored.
- Backpressure: hold out_ready_i=0 for 5 cycles after AND 0xF0F0F0F0&0xFF00FF00 → result 0xF000F000 stable. Raise out_ready_i → out_valid_o drops next cycle, in_ready_o=1.
- Reset at MUL step 10 → all outputs 0 asynchronously, in_ready_o=1 after release. A following ADD 2+3 → 5; ctrl 0101 → result 0, all flags 0.
